// File: rtl/ps2_tx.sv
// ps2_tx: host-to-device PS/2 transmitter.
// Sends one command byte over the open-drain PS2_CLK/PS2_DAT pair and reports
// ACK (done) or NACK/timeout (error). The *_oe outputs request the top level
// to pull the corresponding line low.
// Optional feature macro: PS2_TX_TIMEOUT_EN adds a device-clock watchdog
// (and the TIMEOUT_CYCLES parameter). Without it the block waits for device
// clocks indefinitely and is recovered by reset_n.
module ps2_tx #(
   parameter int INHIBIT_CYCLES = 2500,
   parameter int REQ_CYCLES     = 16,
`ifdef PS2_TX_TIMEOUT_EN
   parameter int TIMEOUT_CYCLES = 50000,
`endif
   parameter int FILTER         = 8
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       ps_clock,
   input  logic       ps_data,
   output logic       ps_clock_oe,
   output logic       ps_data_oe,
   input  logic [7:0] data,
   input  logic       send,
   output logic       bsy,
   output logic       done,
   output logic       error
);

   localparam int CNT_W = $clog2((INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES) + 1;
   localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] REQ_LAST = CNT_W'(REQ_CYCLES - 1);
   localparam int FLT_W = $clog2(FILTER) + 1;
   localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_INHIBIT  = 3'd1,
      S_REQ      = 3'd2,
      S_XFER     = 3'd3,
      S_WAITIDLE = 3'd4,
      S_FINISH   = 3'd5
   } state_t;

   state_t           r_state;
   state_t           w_state_nx;
   logic             w_abort;
   logic             w_accept;
   logic             w_wdog_hit;

   // input conditioning
   logic             r_clk_s1;
   logic             r_clk_s2;
   logic             r_dat_s1;
   logic             r_dat_s2;
   logic             r_clk_filt;
   logic [FLT_W-1:0] r_flt_cnt;
   logic             r_fe;

   // datapath
   logic [CNT_W-1:0] r_cnt;
   logic [7:0]       r_shift;
   logic             r_parity;
   logic [3:0]       r_bitn;
   logic             r_ack;

   // registered outputs
   logic             r_clk_oe;
   logic             r_dat_oe;
   logic             r_bsy;
   logic             r_done;
   logic             r_err;
   logic             w_clk_oe_nx;
   logic             w_dat_oe_nx;
   logic             w_bsy_nx;
   logic             w_done_nx;
   logic             w_err_nx;

   assign w_accept = send & ((r_state == S_IDLE) | (r_state == S_FINISH));

   // Synchronize both pins; debounce the clock and flag its falling edges.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_clk_s1   <= 1'b1;
         r_clk_s2   <= 1'b1;
         r_dat_s1   <= 1'b1;
         r_dat_s2   <= 1'b1;
         r_clk_filt <= 1'b1;
         r_flt_cnt  <= {FLT_W{1'b0}};
         r_fe       <= 1'b0;
      end else begin
         r_clk_s1 <= ps_clock;
         r_clk_s2 <= r_clk_s1;
         r_dat_s1 <= ps_data;
         r_dat_s2 <= r_dat_s1;
         r_fe     <= 1'b0;
         if (r_clk_s2 == r_clk_filt) begin
            r_flt_cnt <= {FLT_W{1'b0}};
         end else if (r_flt_cnt == FLT_LAST) begin
            r_clk_filt <= r_clk_s2;
            r_flt_cnt  <= {FLT_W{1'b0}};
            r_fe       <= ~r_clk_s2;
         end else begin
            r_flt_cnt <= r_flt_cnt + FLT_W'(1);
         end
      end
   end

`ifdef PS2_TX_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   logic [WD_W-1:0] r_wdog;

   // Watchdog: counts while waiting on the device, restarts on every device clock.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_wdog <= {WD_W{1'b0}};
      end else if (((r_state == S_XFER) || (r_state == S_WAITIDLE)) && !r_fe) begin
         r_wdog <= r_wdog + WD_W'(1);
      end else begin
         r_wdog <= {WD_W{1'b0}};
      end
   end

   assign w_wdog_hit = ((r_state == S_XFER) || (r_state == S_WAITIDLE)) && (r_wdog == WD_LAST);
`else
   assign w_wdog_hit = 1'b0;
`endif

   // State register.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Next-state logic; w_abort marks a watchdog exit to FINISH.
   always_comb begin
      w_state_nx = r_state;
      w_abort    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nx = S_INHIBIT;
            else          w_state_nx = S_IDLE;
         end
         S_INHIBIT: begin
            if (r_cnt == INH_LAST) w_state_nx = S_REQ;
            else                   w_state_nx = S_INHIBIT;
         end
         S_REQ: begin
            if (r_cnt == REQ_LAST) w_state_nx = S_XFER;
            else                   w_state_nx = S_REQ;
         end
         S_XFER: begin
            if (r_fe && (r_bitn == 4'd10)) begin
               w_state_nx = S_WAITIDLE;
            end else if (!r_fe && w_wdog_hit) begin
               w_state_nx = S_FINISH;
               w_abort    = 1'b1;
            end else begin
               w_state_nx = S_XFER;
            end
         end
         S_WAITIDLE: begin
            if (r_clk_filt && r_dat_s2) begin
               w_state_nx = S_FINISH;
            end else if (w_wdog_hit) begin
               w_state_nx = S_FINISH;
               w_abort    = 1'b1;
            end else begin
               w_state_nx = S_WAITIDLE;
            end
         end
         S_FINISH: begin
            if (w_accept) w_state_nx = S_INHIBIT;
            else          w_state_nx = S_IDLE;
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   // Output decode from the next state so every output is registered.
   always_comb begin
      w_clk_oe_nx = 1'b0;
      w_dat_oe_nx = 1'b0;
      w_bsy_nx    = 1'b0;
      w_done_nx   = 1'b0;
      w_err_nx    = 1'b0;
      case (w_state_nx)
         S_IDLE: begin
            w_bsy_nx = 1'b0;
         end
         S_INHIBIT: begin
            w_clk_oe_nx = 1'b1;
            w_bsy_nx    = 1'b1;
         end
         S_REQ: begin
            w_clk_oe_nx = 1'b1;
            w_dat_oe_nx = 1'b1;
            w_bsy_nx    = 1'b1;
         end
         S_XFER: begin
            w_bsy_nx = 1'b1;
            if (r_state != S_XFER) begin
               w_dat_oe_nx = 1'b1;               // start bit held until first device clock
            end else if (r_fe) begin
               if (r_bitn < 4'd8)       w_dat_oe_nx = ~r_shift[r_bitn[2:0]];
               else if (r_bitn == 4'd8) w_dat_oe_nx = ~r_parity;
               else                     w_dat_oe_nx = 1'b0;   // stop bit / ACK slot
            end else begin
               w_dat_oe_nx = r_dat_oe;
            end
         end
         S_WAITIDLE: begin
            w_bsy_nx = 1'b1;
         end
         S_FINISH: begin
            w_done_nx = r_ack & ~w_abort;
            w_err_nx  = ~(r_ack & ~w_abort);
         end
         default: begin
            w_bsy_nx = 1'b0;
         end
      endcase
   end

   // Output registers.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_clk_oe <= 1'b0;
         r_dat_oe <= 1'b0;
         r_bsy    <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_clk_oe <= w_clk_oe_nx;
         r_dat_oe <= w_dat_oe_nx;
         r_bsy    <= w_bsy_nx;
         r_done   <= w_done_nx;
         r_err    <= w_err_nx;
      end
   end

   // Phase timer, byte latch, bit counter and ACK capture.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_cnt    <= {CNT_W{1'b0}};
         r_shift  <= 8'h00;
         r_parity <= 1'b0;
         r_bitn   <= 4'd0;
         r_ack    <= 1'b0;
      end else begin
         if ((w_state_nx != r_state) || !((r_state == S_INHIBIT) || (r_state == S_REQ))) begin
            r_cnt <= {CNT_W{1'b0}};
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_accept) begin
            r_shift  <= data;
            r_parity <= ~^data;
            r_bitn   <= 4'd0;
            r_ack    <= 1'b0;
         end else if ((r_state == S_XFER) && r_fe) begin
            if (r_bitn == 4'd10) r_ack <= ~r_dat_s2;
            else                 r_ack <= r_ack;
            r_bitn <= r_bitn + 4'd1;
         end else begin
            r_bitn <= r_bitn;
         end
      end
   end

   assign ps_clock_oe = r_clk_oe;
   assign ps_data_oe  = r_dat_oe;
   assign bsy         = r_bsy;
   assign done        = r_done;
   assign error       = r_err;

endmodule

// File: tb/tb_ps2_tx.sv
// Testbench for ps2_tx: a behavioural PS/2 device drives the shared lines,
// collects the transmitted frame and compares it with a reference frame
// computed from the byte (LSB-first data, odd parity, stop bit).
`timescale 1ns/1ps
module tb_ps2_tx;

   localparam int INH  = 2500;
   localparam int REQ  = 16;
   localparam int FLT  = 8;
   localparam int SLOW = 500;   // half period of a 40 us device clock at 25 MHz
   localparam int FAST = 80;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       send;
   logic [7:0] data;
   logic       dev_clk;
   logic       dev_dat;
   logic       ps_clock;
   logic       ps_data;
   logic       ps_clock_oe;
   logic       ps_data_oe;
   logic       bsy;
   logic       done;
   logic       error;

   int checks = 0;
   int errors = 0;
   int n_done = 0;
   int n_err  = 0;
   int exp_done = 0;
   int exp_err  = 0;

   logic [9:0] fr;
   int         lt;
   logic [7:0] d;
   bit         a;
   int         h;
   int         n;

   always #20 clock = ~clock;

   // open-drain wiring: line low when either side pulls
   assign ps_clock = dev_clk & ~ps_clock_oe;
   assign ps_data  = dev_dat & ~ps_data_oe;

   ps2_tx dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .ps_clock    (ps_clock),
      .ps_data     (ps_data),
      .ps_clock_oe (ps_clock_oe),
      .ps_data_oe  (ps_data_oe),
      .data        (data),
      .send        (send),
      .bsy         (bsy),
      .done        (done),
      .error       (error)
   );

   // pulse counters over the whole run
   always @(posedge clock) begin
      if (done)  n_done <= n_done + 1;
      if (error) n_err  <= n_err + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] ref_frame(input logic [7:0] b);
      logic par;
      par = (($countones(b) % 2) == 0) ? 1'b1 : 1'b0;
      return {1'b1, par, b};
   endfunction

   // Request a transfer and measure the inhibit and request phases.
   task automatic start_xfer(input logic [7:0] b, input bit inject, input logic [7:0] b2);
      int ni;
      int m;
      @(negedge clock);
      data = b;
      send = 1'b1;
      @(negedge clock);
      send = 1'b0;
      data = 8'h00;
      check("bsy_t1", bsy, 1);
      check("clk_oe_t1", ps_clock_oe, 1);
      check("dat_oe_t1", ps_data_oe, 0);
      ni = 0;
      while (ps_data_oe !== 1'b1 && ni < INH + 100) begin
         @(negedge clock);
         ni++;
         if (inject && ni == 100) begin
            send = 1'b1;
            data = b2;
         end else begin
            send = 1'b0;
         end
      end
      send = 1'b0;
      check("inhibit_len", ni, INH);
      m = 0;
      while (ps_clock_oe !== 1'b0 && m < REQ + 50) begin
         @(negedge clock);
         m++;
      end
      check("req_len", m, REQ);
      check("start_bit", ps_data, 0);
   endtask

   // Device: generate nclk clocks, sample data on each rising edge, ACK if asked.
   task automatic dev_run(input int half, input bit ack, input int nclk,
                          output logic [9:0] frame, output int lat1);
      logic prev;
      frame = 10'h000;
      lat1  = 0;
      repeat (half) @(negedge clock);
      for (int k = 1; k <= nclk; k++) begin
         dev_clk = 1'b0;
         prev    = ps_data_oe;
         for (int i = 1; i <= half; i++) begin
            @(negedge clock);
            if (k == 1 && lat1 == 0 && ps_data_oe !== prev) lat1 = i;
         end
         if (k <= 10) frame[k-1] = ps_data;
         dev_clk = 1'b1;
         if (k == 10 && ack) dev_dat = 1'b0;
         if (k == 11) dev_dat = 1'b1;
         else repeat (half) @(negedge clock);
      end
   endtask

   // Clock the frame out, compare it with the model and check the result pulse.
   task automatic finish_xfer(input logic [7:0] b, input int half, input bit ack);
      logic [9:0] frame;
      int         lat1;
      int         nw;
      dev_run(half, ack, 11, frame, lat1);
      check("frame", frame, ref_frame(b));
      if (b[0]) check("bit_latency", lat1, FLT + 3);
      nw = 0;
      while (!(done === 1'b1 || error === 1'b1) && nw < 500) begin
         @(negedge clock);
         nw++;
      end
      check("pulse_seen", nw < 500, 1);
      check("done", done, ack);
      check("error", error, !ack);
      check("bsy_finish", bsy, 0);
      if (ack) exp_done++;
      else     exp_err++;
      @(negedge clock);
      check("pulse_width", {done, error}, 0);
      check("idle_oe", {ps_clock_oe, ps_data_oe}, 0);
   endtask

   initial begin
      reset_n = 1'b0;
      send    = 1'b0;
      data    = 8'h00;
      dev_clk = 1'b1;
      dev_dat = 1'b1;
      repeat (3) @(negedge clock);
      check("rst_clk_oe", ps_clock_oe, 0);
      check("rst_dat_oe", ps_data_oe, 0);
      check("rst_bsy", bsy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      reset_n = 1'b1;
      repeat (5) @(negedge clock);

      // LED command at the nominal 40 us device clock
      start_xfer(8'hED, 1'b0, 8'h00);
      finish_xfer(8'hED, SLOW, 1'b1);

      start_xfer(8'h00, 1'b0, 8'h00);
      finish_xfer(8'h00, FAST, 1'b1);

      // NACK
      d = 8'($urandom);
      start_xfer(d, 1'b0, 8'h00);
      finish_xfer(d, FAST, 1'b0);

      // second send while busy must be ignored
      start_xfer(8'hFF, 1'b1, 8'h55);
      finish_xfer(8'hFF, FAST, 1'b1);

      for (int r = 0; r < 2; r++) begin
         d = 8'($urandom);
         a = 1'($urandom_range(0, 1));
         h = $urandom_range(60, 100);
         start_xfer(d, 1'b0, 8'h00);
         finish_xfer(d, h, a);
      end

      // reset in the middle of the data bits
      d = 8'($urandom);
      start_xfer(d, 1'b0, 8'h00);
      dev_run(FAST, 1'b1, 5, fr, lt);
      reset_n = 1'b0;
      @(negedge clock);
      check("rst_mid_oe", {ps_clock_oe, ps_data_oe}, 0);
      check("rst_mid_bsy", bsy, 0);
      check("rst_mid_pulse", {done, error}, 0);
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (5) @(negedge clock);
      start_xfer(8'hF4, 1'b0, 8'h00);
      finish_xfer(8'hF4, FAST, 1'b1);

`ifdef PS2_TX_TIMEOUT_EN
      // device stops after the 4th clock
      start_xfer(8'hA5, 1'b0, 8'h00);
      dev_run(FAST, 1'b1, 4, fr, lt);
      n = 0;
      while (error !== 1'b1 && n < 60000) begin
         @(negedge clock);
         n++;
      end
      check("timeout_seen", n < 60000, 1);
      check("timeout_window", (n > 49500) && (n <= 50100), 1);
      check("timeout_done", done, 0);
      check("timeout_oe", {ps_clock_oe, ps_data_oe}, 0);
      check("timeout_bsy", bsy, 0);
      exp_err++;
`endif

      repeat (20) @(negedge clock);
      check("done_total", n_done, exp_done);
      check("error_total", n_err, exp_err);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
